// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler instruction sequencer.
//   N            datapath / immediate width
//   PC_W         program-counter width
//   opcode_e     instruction opcodes carried in byte[7:4]
//   state_e      sequencer FSM states
//   alu_op_e     operation select driven into the accumulator ALU
//   flags_t      per-flag write enables (or flag values) for C and Z
package nibbler_pkg;

  localparam int N    = 4;
  localparam int PC_W = 12;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LIT  = 4'h1,
    OP_ADDI = 4'h2,
    OP_CMPI = 4'h3,
    OP_NORI = 4'h4,
    OP_IN   = 4'h5,
    OP_OUT  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JC   = 4'h8,
    OP_JNC  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JNZ  = 4'hB
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FETCH2 = 2'd1,
    EXEC   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_NOR    = 2'd2,
    ALU_PASS_B = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // Jumps (7..B) carry a second byte holding the low 8 bits of the target.
  function automatic logic is_two_byte(input logic [3:0] opcode);
    return (opcode >= 4'h7) && (opcode <= 4'hB);
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational instruction decoder for the Nibbler sequencer.
// All controls are zero outside EXEC so the datapath sees one-cycle strobes.
//   state      current sequencer state
//   opcode     ir[7:4]
//   port       ir[1:0], port index for IN/OUT (3 = no port)
//   alu_op     ALU operation select
//   alu_b_sel  ALU B operand: 0 = immediate, 1 = selected input port
//   in_sel     input port select
//   acc_we     accumulator load strobe
//   out_we     one-hot Out0..Out2 load strobe
//   flags_we   C/Z flag register write enables
//   is_jump    EXEC of a jump-class instruction
module nibbler_decode
  import nibbler_pkg::*;
(
  input  state_e       state,
  input  logic [3:0]   opcode,
  input  logic [1:0]   port,
  output alu_op_e      alu_op,
  output logic         alu_b_sel,
  output logic [1:0]   in_sel,
  output logic         acc_we,
  output logic [2:0]   out_we,
  output flags_t       flags_we,
  output logic         is_jump
);

  logic port_ok;
  assign port_ok = (port != 2'd3);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    in_sel    = 2'd0;
    acc_we    = 1'b0;
    out_we    = 3'b000;
    flags_we  = '0;
    is_jump   = 1'b0;

    if (state == EXEC) begin
      case (opcode_e'(opcode))
        OP_LIT: begin
          alu_op     = ALU_PASS_B;
          acc_we     = 1'b1;
          flags_we.z = 1'b1;
        end
        OP_ADDI: begin
          alu_op     = ALU_ADD;
          acc_we     = 1'b1;
          flags_we.c = 1'b1;
          flags_we.z = 1'b1;
        end
        OP_CMPI: begin
          // Compare only: flags follow the subtraction, accumulator untouched.
          alu_op     = ALU_SUB;
          flags_we.c = 1'b1;
          flags_we.z = 1'b1;
        end
        OP_NORI: begin
          alu_op     = ALU_NOR;
          acc_we     = 1'b1;
          flags_we.z = 1'b1;
        end
        OP_IN: begin
          if (port_ok) begin
            alu_op     = ALU_PASS_B;
            alu_b_sel  = 1'b1;
            in_sel     = port;
            acc_we     = 1'b1;
            flags_we.z = 1'b1;
          end
        end
        OP_OUT: begin
          if (port_ok) out_we = 3'b001 << port;
        end
        OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: is_jump = 1'b1;
        default: ;  // NOP and reserved C..F
      endcase
    end
  end

endmodule

// File: rtl/nibbler_seq.sv
// Instruction sequencer for the 4-bit Nibbler processor. Fetches one or two
// instruction bytes from program ROM, then spends one EXEC cycle driving the
// accumulator datapath and port strobes. Holds pc, ir, lo and the C/Z flags.
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   rom_data   instruction byte at address pc
//   rom_ready  rom_data valid this cycle (ignored in EXEC)
//   alu_c      ALU carry-out of current operation
//   alu_z      ALU result == 0
//   pc         ROM fetch address
//   imm        immediate field of the current instruction
//   alu_op     ADD=0, SUB=1, NOR=2, PASS_B=3
//   alu_b_sel  0 = imm, 1 = selected input port
//   in_sel     input port select
//   acc_we     accumulator load strobe
//   out_we     one-hot Out0..Out2 load strobe
//   C, Z       flag register
module nibbler_seq
  import nibbler_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rom_data,
  input  logic            rom_ready,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [PC_W-1:0] pc,
  output logic [N-1:0]    imm,
  output logic [1:0]      alu_op,
  output logic            alu_b_sel,
  output logic [1:0]      in_sel,
  output logic            acc_we,
  output logic [2:0]      out_we,
  output logic            C,
  output logic            Z
);

  state_e     state_q, state_d;
  logic [7:0] ir;
  logic [7:0] lo;
  alu_op_e    dec_alu_op;
  flags_t     flags_we;
  logic       is_jump;
  logic       taken;

  nibbler_decode u_decode (
    .state     (state_q),
    .opcode    (ir[7:4]),
    .port      (ir[1:0]),
    .alu_op    (dec_alu_op),
    .alu_b_sel (alu_b_sel),
    .in_sel    (in_sel),
    .acc_we    (acc_we),
    .out_we    (out_we),
    .flags_we  (flags_we),
    .is_jump   (is_jump)
  );

  assign alu_op = dec_alu_op;
  assign imm    = ir[N-1:0];

  // Jump condition looks at the flags as they stand at the start of EXEC.
  always_comb begin
    taken = 1'b0;
    case (opcode_e'(ir[7:4]))
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = C;
      OP_JNC:  taken = ~C;
      OP_JZ:   taken = Z;
      OP_JNZ:  taken = ~Z;
      default: taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic. The opcode is taken straight from rom_data in FETCH
  // because ir has not been loaded yet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (rom_ready) state_d = is_two_byte(rom_data[7:4]) ? FETCH2 : EXEC;
      FETCH2:  if (rom_ready) state_d = EXEC;
      EXEC:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Program counter, instruction bytes and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
      lo <= '0;
      C  <= 1'b0;
      Z  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (rom_ready) begin
            ir <= rom_data;
            pc <= pc + PC_W'(1);  // wraps 0xFFF -> 0x000
          end
        end
        FETCH2: begin
          if (rom_ready) begin
            lo <= rom_data;
            pc <= pc + PC_W'(1);
          end
        end
        EXEC: begin
          if (is_jump && taken) pc <= {ir[3:0], lo};
          if (flags_we.c) C <= alu_c;
          if (flags_we.z) Z <= alu_z;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_seq.sv
// Self-checking bench for nibbler_seq. Provides program ROM, a small
// accumulator/ALU datapath that answers alu_c/alu_z, and an instruction-level
// reference model that tracks pc, acc, flags and output ports.
module tb_nibbler_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rom_data;
  logic        rom_ready = 1'b0;
  logic        alu_c, alu_z;
  logic [11:0] pc;
  logic [3:0]  imm;
  logic [1:0]  alu_op, in_sel;
  logic        alu_b_sel, acc_we;
  logic [2:0]  out_we;
  logic        C, Z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibbler_seq dut (
    .clk       (clk),
    .reset     (reset),
    .rom_data  (rom_data),
    .rom_ready (rom_ready),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .pc        (pc),
    .imm       (imm),
    .alu_op    (alu_op),
    .alu_b_sel (alu_b_sel),
    .in_sel    (in_sel),
    .acc_we    (acc_we),
    .out_we    (out_we),
    .C         (C),
    .Z         (Z)
  );

  // Program ROM; while garbage is set the bus carries junk instead.
  logic [7:0] rom [0:4095];
  logic       garbage = 1'b0;
  logic [7:0] junk = 8'h00;
  assign rom_data = garbage ? junk : rom[pc];

  // Environment datapath: accumulator, ALU, input and output ports.
  logic [3:0] acc;
  logic [3:0] outp [3];
  logic [3:0] in_port [3];
  logic [3:0] alu_b;
  logic [4:0] alu_wide;

  always_comb begin
    alu_b = 4'd0;
    if (!alu_b_sel)          alu_b = imm;
    else if (in_sel != 2'd3) alu_b = in_port[in_sel];
    case (alu_op)
      2'd0:    alu_wide = {1'b0, acc} + {1'b0, alu_b};
      2'd1:    alu_wide = {1'b0, acc} + {1'b0, ~alu_b} + 5'd1;  // carry = no borrow
      2'd2:    alu_wide = {1'b0, ~(acc | alu_b)};
      default: alu_wide = {1'b0, alu_b};
    endcase
  end
  assign alu_c = alu_wide[4];
  assign alu_z = (alu_wide[3:0] == 4'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 4'd0;
      for (int i = 0; i < 3; i++) outp[i] <= 4'd0;
    end else begin
      if (acc_we) acc <= alu_wide[3:0];
      for (int i = 0; i < 3; i++) if (out_we[i]) outp[i] <= acc;
    end
  end

  // Instruction-level reference model state.
  logic [11:0] m_pc;
  logic [3:0]  m_acc;
  logic        m_c, m_z;
  logic [3:0]  m_out [3];

  task automatic model_reset();
    m_pc  = 12'h000;
    m_acc = 4'd0;
    m_c   = 1'b0;
    m_z   = 1'b0;
    for (int i = 0; i < 3; i++) m_out[i] = 4'd0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rom_ready = 1'b0;
    garbage   = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Runs one instruction from FETCH to the next FETCH. s1/s2 are the numbers
  // of rom_ready-low cycles inserted before the first/second byte.
  task automatic exec_instr(input int s1, input int s2);
    logic [7:0]  b1, b2;
    logic [3:0]  op, im;
    logic [1:0]  k;
    logic        two, taken, e_acc_we, e_valid, e_bsel;
    logic [2:0]  e_out_we;
    logic [1:0]  e_alu_op, e_insel;
    logic [11:0] start, after_fetch;
    int          sum;

    start       = m_pc;
    b1          = rom[start];
    b2          = rom[start + 12'd1];
    op          = b1[7:4];
    im          = b1[3:0];
    k           = im[1:0];
    two         = (op >= 4'd7) && (op <= 4'd11);
    after_fetch = start + (two ? 12'd2 : 12'd1);
    e_acc_we    = (op == 4'd1) || (op == 4'd2) || (op == 4'd4) || (op == 4'd5 && k != 2'd3);
    e_out_we    = (op == 4'd6 && k != 2'd3) ? (3'b001 << k) : 3'b000;
    e_valid     = (op >= 4'd1 && op <= 4'd4) || (op == 4'd5 && k != 2'd3);
    case (op)
      4'd2:    e_alu_op = 2'd0;
      4'd3:    e_alu_op = 2'd1;
      4'd4:    e_alu_op = 2'd2;
      default: e_alu_op = 2'd3;
    endcase
    e_bsel  = (op == 4'd5 && k != 2'd3);
    e_insel = e_bsel ? k : 2'd0;

    for (int i = 0; i < s1; i++) begin
      rom_ready = 1'b0; garbage = 1'b1; junk = 8'($urandom);
      #1;
      checks++;
      if (pc !== start || acc_we !== 1'b0 || out_we !== 3'b000) begin
        errors++;
        $display("FAIL stall_fetch pc=%03h acc_we=%b out_we=%b expected pc=%03h no strobes",
                 pc, acc_we, out_we, start);
      end
      @(negedge clk);
    end
    rom_ready = 1'b1; garbage = 1'b0;
    @(negedge clk);

    if (two) begin
      for (int i = 0; i < s2; i++) begin
        rom_ready = 1'b0; garbage = 1'b1; junk = 8'($urandom);
        #1;
        checks++;
        if (pc !== start + 12'd1 || acc_we !== 1'b0 || out_we !== 3'b000) begin
          errors++;
          $display("FAIL stall_fetch2 pc=%03h acc_we=%b out_we=%b expected pc=%03h no strobes",
                   pc, acc_we, out_we, start + 12'd1);
        end
        @(negedge clk);
      end
      rom_ready = 1'b1; garbage = 1'b0;
      @(negedge clk);
    end

    // EXEC cycle: rom_ready and rom_data are noise here and must be ignored.
    rom_ready = 1'($urandom); garbage = 1'b1; junk = 8'($urandom);
    #1;
    checks++;
    if (acc_we !== e_acc_we || out_we !== e_out_we || imm !== im || pc !== after_fetch) begin
      errors++;
      $display("FAIL exec_strobes op=%h acc_we=%b out_we=%b imm=%h pc=%03h expected %b %b %h %03h",
               op, acc_we, out_we, imm, pc, e_acc_we, e_out_we, im, after_fetch);
    end
    if (e_valid) begin
      checks++;
      if (alu_op !== e_alu_op || alu_b_sel !== e_bsel || in_sel !== e_insel) begin
        errors++;
        $display("FAIL exec_alu op=%h alu_op=%0d b_sel=%b in_sel=%0d expected %0d %b %0d",
                 op, alu_op, alu_b_sel, in_sel, e_alu_op, e_bsel, e_insel);
      end
    end

    // Architectural effect of the instruction.
    taken = (op == 4'd7) || (op == 4'd8 && m_c) || (op == 4'd9 && !m_c) ||
            (op == 4'd10 && m_z) || (op == 4'd11 && !m_z);
    case (op)
      4'd1: begin m_acc = im; m_z = (im == 4'd0); end
      4'd2: begin
        sum   = int'(m_acc) + int'(im);
        m_c   = (sum > 15);
        m_acc = 4'(sum % 16);
        m_z   = (m_acc == 4'd0);
      end
      4'd3: begin m_c = (m_acc >= im); m_z = (m_acc == im); end
      4'd4: begin m_acc = ~(m_acc | im); m_z = (m_acc == 4'd0); end
      4'd5: if (k != 2'd3) begin m_acc = in_port[k]; m_z = (m_acc == 4'd0); end
      4'd6: if (k != 2'd3) m_out[k] = m_acc;
      default: ;
    endcase
    m_pc = taken ? {im, b2} : after_fetch;

    @(negedge clk);
    rom_ready = 1'b1; garbage = 1'b0;
    #1;
    checks++;
    if (pc !== m_pc || C !== m_c || Z !== m_z || acc !== m_acc) begin
      errors++;
      $display("FAIL post_exec op=%h pc=%03h C=%b Z=%b acc=%h expected %03h %b %b %h",
               op, pc, C, Z, acc, m_pc, m_c, m_z, m_acc);
    end
    checks++;
    if (outp[0] !== m_out[0] || outp[1] !== m_out[1] || outp[2] !== m_out[2]) begin
      errors++;
      $display("FAIL out_ports got %h %h %h expected %h %h %h",
               outp[0], outp[1], outp[2], m_out[0], m_out[1], m_out[2]);
    end
  endtask

  task automatic test_reset();
    clear_rom();
    for (int i = 0; i < 3; i++) in_port[i] = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;  // no clock edge yet: reset must act asynchronously
    checks++;
    if (pc !== 12'h000 || imm !== 4'h0 || C !== 1'b0 || Z !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs pc=%03h imm=%h C=%b Z=%b expected all zero", pc, imm, C, Z);
    end
    checks++;
    if (acc_we !== 1'b0 || out_we !== 3'b000 || alu_op !== 2'd0 || in_sel !== 2'd0 || alu_b_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes acc_we=%b out_we=%b alu_op=%0d in_sel=%0d b_sel=%b expected all zero",
               acc_we, out_we, alu_op, in_sel, alu_b_sel);
    end
  endtask

  task automatic test_first_fetch();
    clear_rom();
    rom[0] = 8'h16;
    do_reset();
    #1;
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL first_pc got %03h expected 000", pc);
    end
    exec_instr(0, 0);
  endtask

  task automatic test_addi_carry();
    clear_rom();
    rom[0] = 8'h1F;
    rom[1] = 8'h21;
    do_reset();
    exec_instr(0, 0);
    exec_instr(0, 0);
    checks++;
    if (C !== 1'b1 || Z !== 1'b1) begin
      errors++;
      $display("FAIL addi_carry C=%b Z=%b expected 1 1", C, Z);
    end
  endtask

  task automatic test_cond_jumps();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'hA2; rom[3] = 8'h34;
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(0, 0);
    checks++;
    if (pc !== 12'h234) begin
      errors++;
      $display("FAIL jz_taken pc=%03h expected 234", pc);
    end
    rom[1] = 8'h32;
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(0, 0);
    checks++;
    if (pc !== 12'h004) begin
      errors++;
      $display("FAIL jz_not_taken pc=%03h expected 004", pc);
    end
  endtask

  task automatic test_port_io();
    clear_rom();
    in_port[0] = 4'd9; in_port[1] = 4'd4; in_port[2] = 4'd7;
    rom[0] = 8'h51; rom[1] = 8'h62; rom[2] = 8'h63;
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(0, 0);
    checks++;
    if (outp[2] !== 4'd4 || acc !== 4'd4) begin
      errors++;
      $display("FAIL port_io out2=%h acc=%h expected 4 4", outp[2], acc);
    end
  endtask

  task automatic test_rom_stall();
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'h10;
    do_reset();
    exec_instr(0, 3);
    checks++;
    if (pc !== 12'h010) begin
      errors++;
      $display("FAIL stall_jmp pc=%03h expected 010", pc);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = 8'h16;
    do_reset();
    rom_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (acc_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_setup acc_we=%b expected 1", acc_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (acc_we !== 1'b0 || alu_op !== 2'd0 || pc !== 12'h000 || imm !== 4'h0 || out_we !== 3'b000) begin
      errors++;
      $display("FAIL mid_exec_reset acc_we=%b alu_op=%0d pc=%03h imm=%h out_we=%b expected all zero",
               acc_we, alu_op, pc, imm, out_we);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exec_instr(1, 0);
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = 8'h7F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h00;
    do_reset();
    exec_instr(0, 0);
    exec_instr(0, 0);
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL pc_wrap pc=%03h expected 000", pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) in_port[i] = 4'($urandom);
      exec_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_addi_carry();
    test_cond_jumps();
    test_port_io();
    test_rom_stall();
    test_reset_mid_exec();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
